// File: rtl/barrett_reduce_pipe_pkg.sv
// Shared Kyber constants and compile-time helpers for Barrett reduction.
// The constant functions are reused by the NTT/INTT blocks as well.
package barrett_reduce_pipe_pkg;

    localparam int KYBER_Q = 3329;

    // Ceiling log2 of v; returns 0 for v <= 1.
    function automatic int clog2(input logic [127:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 128; i++) begin
            if ((128'd1 << i) < v) n = i + 1;
        end
        return n;
    endfunction

    // Barrett multiplier M = floor(2^k / q).
    function automatic logic [127:0] barrett_m(input int q, input int k);
        return (128'd1 << k) / 128'(q);
    endfunction

    // Smallest multiple of q that is >= 2^(in_w-1). Adding it to any signed
    // in_w-bit value gives a non-negative number congruent to it mod q.
    function automatic logic [127:0] signed_off(input int q, input int in_w);
        logic [127:0] half;
        logic [127:0] qq;
        half = 128'd1 << (in_w - 1);
        qq   = 128'(q);
        return ((half + qq - 128'd1) / qq) * qq;
    endfunction

endpackage

// File: rtl/barrett_reduce_pipe_lane.sv
// One lane of the 3-stage Barrett reduction datapath.
// Stage enables come from the shared control chain in the top; this module
// holds only data registers, so all lanes stay in lock-step.
module barrett_reduce_pipe_lane
    import barrett_reduce_pipe_pkg::*;
#(
    parameter int Q     = KYBER_Q,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int K     = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en1,
    input  logic             en2,
    input  logic             en3,
    input  logic             sgn,
    input  logic [IN_W-1:0]  x,
    output logic [OUT_W-1:0] y
);

    // u needs one extra bit so a biased signed value never wraps.
    localparam int UW = IN_W + 1;
    // u * M is below 2^(UW+K), so this width holds the full product.
    localparam int PW = UW + K;

    localparam logic [UW-1:0] OFF = UW'(signed_off(Q, IN_W));
    localparam logic [K-1:0]  M   = K'(barrett_m(Q, K));
    localparam logic [UW-1:0] QU  = UW'(Q);

    logic [UW-1:0] u_in;
    logic [UW-1:0] u1;
    logic [UW-1:0] t1;
    logic [UW-1:0] u2;
    logic [UW-1:0] t2;
    logic [UW-1:0] tq;
    logic [UW-1:0] r;
    logic [UW-1:0] red;

    // Signed inputs are sign-extended and biased by a multiple of Q; the
    // modular add is exact because the true sum lies in [0, 2^UW).
    assign u_in = sgn ? ({x[IN_W-1], x} + OFF) : {1'b0, x};

    // Quotient estimate; it undershoots the true quotient by at most one.
    assign t1 = UW'((PW'(u1) * PW'(M)) >> K);

    // t*Q <= u, so the product and difference fit in UW bits.
    assign tq  = t2 * QU;
    assign r   = u2 - tq;
    assign red = (r >= QU) ? (r - QU) : r;

    // S1: capture the non-negative operand
    always_ff @(posedge clk) begin
        if (rst)      u1 <= '0;
        else if (en1) u1 <= u_in;
    end

    // S2: carry the operand forward with its quotient estimate
    always_ff @(posedge clk) begin
        if (rst) begin
            u2 <= '0;
            t2 <= '0;
        end else if (en2) begin
            u2 <= u1;
            t2 <= t1;
        end
    end

    // S3: single conditional subtract brings r from [0,2Q) into [0,Q)
    always_ff @(posedge clk) begin
        if (rst)      y <= '0;
        else if (en3) y <= OUT_W'(red);
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Multi-lane pipelined Barrett reduction (x mod Q) with valid/ready on both
// sides. The top owns the single valid chain and tag pipe; lanes are pure
// datapath driven by the per-stage load enables.
module barrett_reduce_pipe
    import barrett_reduce_pipe_pkg::*;
#(
    parameter int Q     = KYBER_Q,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int LANES = 2,
    parameter int K     = 33,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag
);

    // Stage valid bits, S1..S3; S3 is the output register.
    logic [3:1] vld_pipe;
    logic       ld1;
    logic       ld2;
    logic       ld3;
    logic       en1;
    logic       en2;
    logic       en3;

    logic [TAG_W-1:0] tag1;
    logic [TAG_W-1:0] tag2;

    logic [LANES-1:0][OUT_W-1:0] lane_out;

    // A stage may load when it is empty or its contents move on this cycle.
    // The chain is combinational from out_ready, so a full pipe accepts a new
    // input in the same cycle the consumer drains, without a bubble.
    assign ld3 = !vld_pipe[3] || out_ready;
    assign ld2 = !vld_pipe[2] || ld3;
    assign ld1 = !vld_pipe[1] || ld2;

    assign in_ready  = ld1;
    assign out_valid = vld_pipe[3];

    // Data registers only move when a real transaction enters the stage, so
    // out_data stays put while the output is idle.
    assign en1 = ld1 && in_valid;
    assign en2 = ld2 && vld_pipe[1];
    assign en3 = ld3 && vld_pipe[2];

    // Valid chain: each loading stage takes the valid of the stage before it
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            if (ld1) vld_pipe[1] <= in_valid;
            if (ld2) vld_pipe[2] <= vld_pipe[1];
            if (ld3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    // Tag sideband travels alongside the data with the same enables
    always_ff @(posedge clk) begin
        if (rst) begin
            tag1    <= '0;
            tag2    <= '0;
            out_tag <= '0;
        end else begin
            if (en1) tag1    <= in_tag;
            if (en2) tag2    <= tag1;
            if (en3) out_tag <= tag2;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        barrett_reduce_pipe_lane #(
            .Q     (Q),
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .K     (K)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en1 (en1),
            .en2 (en2),
            .en3 (en3),
            .sgn (in_signed),
            .x   (in_data[i*IN_W +: IN_W]),
            .y   (lane_out[i])
        );
    end

    assign out_data = lane_out;

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed and randomised checks of barrett_reduce_pipe with a mod-Q
// reference model and an in-order scoreboard.
module tb_barrett_reduce_pipe;

    localparam int Q     = 3329;
    localparam int IN_W  = 32;
    localparam int OUT_W = 16;
    localparam int LANES = 2;
    localparam int K     = 33;
    localparam int TAG_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_signed;
    logic [LANES*IN_W-1:0]  in_data;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [TAG_W-1:0]       out_tag;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          n_out  = 0;
    logic        fire_in;
    logic        fire_out;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic [7:0]  hold_tag;

    always #5 clk = ~clk;

    barrett_reduce_pipe #(
        .Q(Q), .IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES), .K(K), .TAG_W(TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    function automatic logic [15:0] ref_mod(input logic [31:0] x, input logic sgn);
        longint v;
        longint r;
        v = sgn ? longint'($signed(x)) : longint'({32'd0, x});
        r = v % longint'(Q);
        if (r < 0) r = r + longint'(Q);
        return 16'(r);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock cycle: inputs are already set; sample handshakes mid-cycle,
    // update scoreboard, then move to just after the next rising edge.
    task automatic tick();
        exp_t e;
        #2;
        fire_in  = in_valid && in_ready;
        fire_out = out_valid && out_ready;
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(hold_data));
                chk("hold_tag", 64'(out_tag), 64'(hold_tag));
            end
            if (fire_out) begin
                chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.data));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                end
                n_out++;
            end
            if (fire_in) begin
                e.data = {ref_mod(in_data[63:32], in_signed), ref_mod(in_data[31:0], in_signed)};
                e.tag  = in_tag;
                sb.push_back(e);
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            hold_tag  = out_tag;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_vec(input int tg);
        in_signed = 1'($urandom_range(0, 1));
        in_data   = {$urandom(), $urandom()};
        in_tag    = 8'(tg);
    endtask

    // Single transaction into an empty pipe: checks acceptance, 3-cycle
    // latency and the hand-computed lane results.
    task automatic send_check(input string name, input logic sgn, input logic [31:0] x0,
                              input logic [31:0] x1, input logic [7:0] tg,
                              input logic [15:0] e0, input logic [15:0] e1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_signed = sgn;
        in_data   = {x1, x0};
        in_tag    = tg;
        #1;
        chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk({name, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_lat2"}, 64'(out_valid), 64'd0);
        tick();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_data"}, 64'(out_data), 64'({e1, e0}));
        chk({name, "_tag"}, 64'(out_tag), 64'(tg));
        tick();
    endtask

    initial begin
        int acc;
        int sent;
        int cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_signed = 1'b0; in_data = '0; in_tag = '0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);

        // Directed vectors
        send_check("u_zero_q", 1'b0, 32'd0, 32'd3329, 8'h11, 16'd0, 16'd0);
        send_check("u_q1_ones", 1'b0, 32'd3328, 32'hFFFF_FFFF, 8'h22, 16'd3328, 16'd1352);
        send_check("s_neg", 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 8'h33, 16'd3328, 16'd988);
        send_check("u_neg", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 8'h44, 16'd1352, 16'd2341);

        // Throughput: back-to-back with out_ready held high
        n_out = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            new_vec(i);
            in_valid = 1'b1;
            tick();
            chk("tp_accept", 64'(fire_in), 64'd1);
            if (i >= 2) chk("tp_contig", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("tp_tail1", 64'(out_valid), 64'd1);
        tick();
        chk("tp_tail2", 64'(out_valid), 64'd1);
        tick();
        chk("tp_empty", 64'(out_valid), 64'd0);
        chk("tp_count", 64'(n_out), 64'd100);
        chk("tp_sb_empty", 64'(sb.size()), 64'd0);

        // Backpressure: consumer stalls for 6 cycles
        n_out = 0; acc = 0;
        out_ready = 1'b0;
        new_vec(200);
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (fire_in) begin
                acc++;
                new_vec(200 + acc);
            end
        end
        chk("bp_accepts", 64'(acc), 64'd3);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        cyc = 0;
        while (acc < 8 && cyc < 50) begin
            tick();
            cyc++;
            if (fire_in) begin
                acc++;
                new_vec(200 + acc);
            end
        end
        in_valid = 1'b0;
        while ((sb.size() != 0 || out_valid) && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("bp_no_timeout", 64'(cyc < 100), 64'd1);
        chk("bp_count", 64'(n_out), 64'd8);

        // Random valid/ready toggling; source holds its word until accepted
        n_out = 0; sent = 0; cyc = 0;
        in_valid = 1'b0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
            if (!in_valid && sent < 1000 && ($urandom_range(0, 1) == 1)) begin
                new_vec(sent);
                in_valid = 1'b1;
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (fire_in) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rnd_no_timeout", 64'(cyc < 20000), 64'd1);
        chk("rnd_count", 64'(n_out), 64'd1000);

        // Reset with three transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            new_vec(90 + i);
            in_valid = 1'b1;
            tick();
            chk("rst_fill_accept", 64'(fire_in), 64'd1);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_data", 64'(out_data), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_silent", 64'(out_valid), 64'd0);
        end
        send_check("post_rst", 1'b0, 32'd7, 32'd3330, 8'h5A, 16'd7, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
